// File: rtl/ps2_move_decoder.sv
// PS/2 scancode decoder producing held left/right move levels and a stretched restart pulse.
// Optional feature: define PS2_STUCK_TIMEOUT_EN to clear held keys after TIMEOUT_CYCLES idle cycles.
module ps2_move_decoder #(
    parameter logic [31:0] RESTART_HOLD   = 32'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
) (
    input  logic       clock,
    input  logic       ctrl_reset_n,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       move_left,
    output logic       move_right,
    output logic       game_status
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_D     = 8'h23;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    logic [1:0]  state_reg, state_next;
    logic        left_arrow_reg, left_arrow_next;
    logic        right_arrow_reg, right_arrow_next;
    logic        key_a_reg, key_a_next;
    logic        key_d_reg, key_d_next;
    logic [31:0] hold_reg, hold_next;
    logic        do_make, do_break, is_ext;

`ifdef PS2_STUCK_TIMEOUT_EN
    logic [31:0] idle_cnt_reg, idle_cnt_next;
    logic        timeout_hit;

    assign timeout_hit   = (idle_cnt_reg >= TIMEOUT_CYCLES);
    assign idle_cnt_next = ps2_key_pressed ? 32'd0 :
                           (idle_cnt_reg == 32'hFFFF_FFFF) ? idle_cnt_reg : idle_cnt_reg + 32'd1;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            idle_cnt_reg <= 32'd0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`endif

    // Prefix tracking: decide whether this byte is a make, a break, or only a prefix.
    always_comb begin
        state_next = state_reg;
        do_make    = 1'b0;
        do_break   = 1'b0;
        is_ext     = 1'b0;
        if (ps2_key_pressed) begin
            case (state_reg)
                IDLE: begin
                    if (ps2_key_data == CODE_EXT) begin
                        state_next = EXT;
                    end else if (ps2_key_data == CODE_BRK) begin
                        state_next = BRK;
                    end else begin
                        do_make = 1'b1;
                    end
                end
                EXT: begin
                    if (ps2_key_data == CODE_BRK) begin
                        state_next = EXT_BRK;
                    end else if (ps2_key_data != CODE_EXT) begin
                        do_make    = 1'b1;
                        is_ext     = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    do_break   = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    do_break   = 1'b1;
                    is_ext     = 1'b1;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Key map: makes set a held flag, breaks clear it; Enter make reloads the hold counter.
    always_comb begin
        left_arrow_next  = left_arrow_reg;
        right_arrow_next = right_arrow_reg;
        key_a_next       = key_a_reg;
        key_d_next       = key_d_reg;
        hold_next        = (hold_reg != 32'd0) ? hold_reg - 32'd1 : 32'd0;
        if (do_make || do_break) begin
            if (is_ext) begin
                if (ps2_key_data == CODE_LEFT)  left_arrow_next  = do_make;
                if (ps2_key_data == CODE_RIGHT) right_arrow_next = do_make;
            end else begin
                if (ps2_key_data == CODE_A) key_a_next = do_make;
                if (ps2_key_data == CODE_D) key_d_next = do_make;
                if (ps2_key_data == CODE_ENTER && do_make) hold_next = RESTART_HOLD;
            end
        end
`ifdef PS2_STUCK_TIMEOUT_EN
        if (!ps2_key_pressed && timeout_hit) begin
            left_arrow_next  = 1'b0;
            right_arrow_next = 1'b0;
            key_a_next       = 1'b0;
            key_d_next       = 1'b0;
        end
`endif
    end

    logic [1:0] state_final;
`ifdef PS2_STUCK_TIMEOUT_EN
    assign state_final = (!ps2_key_pressed && timeout_hit) ? IDLE : state_next;
`else
    assign state_final = state_next;
`endif

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_reg       <= IDLE;
            left_arrow_reg  <= 1'b0;
            right_arrow_reg <= 1'b0;
            key_a_reg       <= 1'b0;
            key_d_reg       <= 1'b0;
            hold_reg        <= 32'd0;
            move_left       <= 1'b0;
            move_right      <= 1'b0;
            game_status     <= 1'b0;
        end else begin
            state_reg       <= state_final;
            left_arrow_reg  <= left_arrow_next;
            right_arrow_reg <= right_arrow_next;
            key_a_reg       <= key_a_next;
            key_d_reg       <= key_d_next;
            hold_reg        <= hold_next;
            move_left       <= left_arrow_next | key_a_next;
            move_right      <= right_arrow_next | key_d_next;
            game_status     <= (hold_next != 32'd0);
        end
    end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Self-checking bench for ps2_move_decoder: directed scenarios plus randomized bytes against a key-level model.
module tb_ps2_move_decoder;

    localparam logic [31:0] HOLD = 32'd4;
    localparam logic [31:0] TMO  = 32'd10;

    logic       clock = 1'b0;
    logic       ctrl_reset_n = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       ps2_key_pressed = 1'b0;
    logic       move_left, move_right, game_status;

    int checks = 0;
    int errors = 0;

    // Reference model: prefix flags, held keys, remaining restart cycles.
    bit m_ext, m_brk;
    bit m_la, m_ra, m_a, m_d;
    int m_rem;

    ps2_move_decoder #(.RESTART_HOLD(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
        .clock          (clock),
        .ctrl_reset_n   (ctrl_reset_n),
        .ps2_key_data   (ps2_key_data),
        .ps2_key_pressed(ps2_key_pressed),
        .move_left      (move_left),
        .move_right     (move_right),
        .game_status    (game_status)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_ext = 0; m_brk = 0;
        m_la = 0; m_ra = 0; m_a = 0; m_d = 0;
        m_rem = 0;
    endtask

    task automatic model_key(input bit ext, input logic [7:0] b, input bit make);
        if (ext) begin
            if (b == 8'h6B) m_la = make;
            if (b == 8'h74) m_ra = make;
        end else begin
            if (b == 8'h1C) m_a = make;
            if (b == 8'h23) m_d = make;
        end
    endtask

    task automatic model_cycle(input bit pressed, input logic [7:0] b);
        bool_enter: begin end
        if (m_rem > 0) m_rem = m_rem - 1;
        if (pressed) begin
            if (m_brk) begin
                model_key(m_ext, b, 1'b0);
                m_ext = 0; m_brk = 0;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else begin
                model_key(m_ext, b, 1'b1);
                if (!m_ext && b == 8'h5A) m_rem = int'(HOLD);
                m_ext = 0;
            end
        end
    endtask

    // Called at a negedge: present a byte for one cycle, return at the next negedge.
    task automatic strobe(input logic [7:0] b);
        ps2_key_data = b;
        ps2_key_pressed = 1'b1;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        $display("strobe %02h -> left=%0b right=%0b status=%0b", b, move_left, move_right, game_status);
    endtask

    task automatic do_reset();
        @(negedge clock);
        ctrl_reset_n = 1'b0;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        strobe(8'h1C);
        strobe(8'h5A);
        #2 ctrl_reset_n = 1'b0;
        #1;
        checks++;
        if ({move_left, move_right, game_status} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async: got %03b want 000", {move_left, move_right, game_status});
        end
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        model_reset();
        @(negedge clock);
        checks++;
        if ({move_left, move_right, game_status} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got %03b want 000", {move_left, move_right, game_status});
        end
    endtask

    task automatic test_arrow_left();
        do_reset();
        strobe(8'hE0);
        strobe(8'h6B);
        checks++;
        if (move_left !== 1'b1) begin
            errors++; $display("FAIL arrow_make: move_left=%0b want 1", move_left);
        end
        strobe(8'hE0);
        strobe(8'h6B);
        checks++;
        if (move_left !== 1'b1) begin
            errors++; $display("FAIL arrow_typematic: move_left=%0b want 1", move_left);
        end
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h6B);
        checks++;
        if (move_left !== 1'b0) begin
            errors++; $display("FAIL arrow_break: move_left=%0b want 0", move_left);
        end
    endtask

    task automatic test_both_dirs();
        do_reset();
        strobe(8'h1C);
        strobe(8'hE0);
        strobe(8'h74);
        checks++;
        if ({move_left, move_right} !== 2'b11) begin
            errors++; $display("FAIL both_held: got %02b want 11", {move_left, move_right});
        end
        strobe(8'hF0);
        strobe(8'h1C);
        checks++;
        if ({move_left, move_right} !== 2'b01) begin
            errors++; $display("FAIL a_released: got %02b want 01", {move_left, move_right});
        end
        strobe(8'hAA);
        strobe(8'hFE);
        checks++;
        if ({move_left, move_right} !== 2'b01) begin
            errors++; $display("FAIL ignored_bytes: got %02b want 01", {move_left, move_right});
        end
    endtask

    task automatic test_restart();
        int cnt;
        do_reset();
        strobe(8'h5A);
        cnt = 0;
        while (game_status === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clock);
        end
        checks++;
        if (cnt != int'(HOLD)) begin
            errors++; $display("FAIL restart_len: high %0d cycles want %0d", cnt, HOLD);
        end
        strobe(8'h5A);
        @(negedge clock);
        strobe(8'h5A);
        cnt = 0;
        while (game_status === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clock);
        end
        checks++;
        if (cnt != int'(HOLD)) begin
            errors++; $display("FAIL restart_extend: high %0d cycles after reload want %0d", cnt, HOLD);
        end
        strobe(8'hF0);
        strobe(8'h5A);
        checks++;
        if (game_status !== 1'b0) begin
            errors++; $display("FAIL enter_break: game_status=%0b want 0", game_status);
        end
    endtask

    task automatic test_reset_midseq();
        do_reset();
        strobe(8'hE0);
        strobe(8'hF0);
        ctrl_reset_n = 1'b0;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        strobe(8'h6B);
        checks++;
        if (move_left !== 1'b0) begin
            errors++; $display("FAIL reset_midseq: move_left=%0b want 0", move_left);
        end
        strobe(8'hE0);
        strobe(8'h6B);
        checks++;
        if (move_left !== 1'b1) begin
            errors++; $display("FAIL after_midseq: move_left=%0b want 1", move_left);
        end
    endtask

    task automatic test_timeout();
        bit want;
        do_reset();
        strobe(8'h23);
        repeat (5) @(negedge clock);
        checks++;
        if (move_right !== 1'b1) begin
            errors++; $display("FAIL timeout_early: move_right=%0b want 1", move_right);
        end
        repeat (7) @(negedge clock);
`ifdef PS2_STUCK_TIMEOUT_EN
        want = 1'b0;
`else
        want = 1'b1;
`endif
        checks++;
        if (move_right !== want) begin
            errors++; $display("FAIL timeout_idle: move_right=%0b want %0b", move_right, want);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [13];
        logic [7:0] b;
        bit pressed;
        int idle_run;
        pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C, 8'h23, 8'h5A, 8'hAA,
                 8'hFA, 8'hFC, 8'hFE, 8'hE1, 8'h00};
        do_reset();
        idle_run = 0;
        for (int i = 0; i < 300; i++) begin
            pressed = ($urandom_range(0, 2) != 0) || (idle_run >= 4);
            b = pool[$urandom_range(0, 12)];
            if (b == 8'h00) b = 8'($urandom);
            idle_run = pressed ? 0 : idle_run + 1;
            ps2_key_data = b;
            ps2_key_pressed = pressed;
            model_cycle(pressed, b);
            @(negedge clock);
            ps2_key_pressed = 1'b0;
            checks++;
            if ({move_left, move_right, game_status} !==
                {m_la | m_a, m_ra | m_d, m_rem > 0}) begin
                errors++;
                $display("FAIL random[%0d] byte=%02h strobe=%0b: got %03b want %03b", i, b, pressed,
                         {move_left, move_right, game_status}, {m_la | m_a, m_ra | m_d, m_rem > 0});
            end
        end
        $display("random: 300 cycles compared");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arrow_left();
        test_both_dirs();
        test_restart();
        test_reset_midseq();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_move_decoder.md
PS2_MOVE_DECODER -- requirements
Module: ps2_move_decoder

Interface
REQ-001 Parameter RESTART_HOLD, default 32'd50000, number of cycles game_status stays high after a restart key press.
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd50000000, idle-byte limit used only when PS2_STUCK_TIMEOUT_EN is defined.
REQ-003 clock  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 ctrl_reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_key_data  input  8  scancode byte from the PS/2 receiver.
REQ-006 ps2_key_pressed  input  1  one-cycle strobe marking ps2_key_data valid.
REQ-007 move_left  output  1  level, high while a left key is held; feeds CPU register $1.
REQ-008 move_right  output  1  level, high while a right key is held; feeds CPU register $2.
REQ-009 game_status  output  1  restart request, stretched to RESTART_HOLD cycles; feeds CPU register $3.

Function
REQ-010 Bytes SHALL be consumed only in cycles where ps2_key_pressed=1; all other cycles SHALL leave the FSM and held flags unchanged.
REQ-011 The FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen).
REQ-012 From IDLE: E0 goes to EXT, F0 goes to BRK, and any other byte is make-decoded (non-extended) with the FSM staying in IDLE.
REQ-013 From EXT: F0 goes to EXT_BRK, E0 stays in EXT, and any other byte is make-decoded (extended) and returns to IDLE.
REQ-014 From BRK: the byte is break-decoded (non-extended) and the FSM returns to IDLE.
REQ-015 From EXT_BRK: the byte is break-decoded (extended) and the FSM returns to IDLE.
REQ-016 Decode map: extended 6B = left arrow, extended 74 = right arrow, non-extended 1C = A (left), non-extended 23 = D (right), non-extended 5A = Enter (restart).
REQ-017 Four independent held flags SHALL exist (left arrow, A, right arrow, D); a make sets its flag and a break clears it.
REQ-018 move_left SHALL equal left arrow OR A; move_right SHALL equal right arrow OR D.
REQ-019 Left and right may both be high at once; no priority is applied.
REQ-020 Unmapped codes, and bytes AA, FA, FC, FE and E1, SHALL be ignored without changing any flag; the FSM still follows REQ-012..015.
REQ-021 All outputs SHALL be registered, so a strobe in cycle n is visible on the outputs in cycle n+1.
REQ-022 A make of Enter SHALL load a 32-bit hold counter with RESTART_HOLD and assert game_status from the next cycle.
REQ-023 game_status SHALL stay high exactly RESTART_HOLD cycles, then drop to 0.
REQ-024 A repeated Enter make while game_status is high SHALL reload the counter, extending the pulse.
REQ-025 An Enter break SHALL have no effect on game_status.
REQ-026 A typematic repeat make of an already-held key SHALL leave its flag at 1.

Reset
REQ-027 While ctrl_reset_n=0, the block SHALL immediately force the FSM to IDLE, clear all held flags and counters, and drive move_left, move_right and game_status to 0.
REQ-028 A reset asserted mid-sequence (for example after E0 F0) SHALL discard the pending prefix; the first byte after reset is decoded from IDLE.

Configuration
REQ-029 With macro PS2_STUCK_TIMEOUT_EN defined, a 32-bit idle counter SHALL count cycles since the last strobe and reset to 0 on every strobe.
REQ-030 With PS2_STUCK_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL clear all held flags and return the FSM to IDLE in the next cycle, without changing game_status.
REQ-031 Without PS2_STUCK_TIMEOUT_EN, no idle counter SHALL exist and held flags SHALL persist indefinitely.

Verification
REQ-032 Strobe E0, 6B -> move_left=1 one cycle after the 6B strobe; then E0, F0, 6B -> move_left=0 one cycle after the final strobe.
REQ-033 Strobe 1C, then E0, 74 -> move_left=1 and move_right=1; then F0, 1C -> move_left=0 and move_right=1.
REQ-034 With RESTART_HOLD=4, strobe 5A -> game_status high for exactly 4 cycles; a second 5A at cycle 2 -> high 4 cycles from the second strobe.
REQ-035 Strobe E0, F0, then assert ctrl_reset_n=0 for one cycle, then strobe 6B -> move_left=0 throughout (6B decoded as non-extended from IDLE, unmapped).
REQ-036 With PS2_STUCK_TIMEOUT_EN defined and TIMEOUT_CYCLES=10, strobe 23 then idle 10 cycles -> move_right drops to 0; without the macro -> move_right remains 1.
